// File: rtl/fir_result_fifo_pkg.sv
// Shared accelerator definitions: the result-word width, the drop-counter width and the FIFO status bundle.
package fir_result_fifo_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned DROP_W     = 8;
   // The count field is sized for the largest supported depth (64 entries).
   localparam int unsigned CNT_MAX_W  = 7;

   typedef struct packed {
      logic [CNT_MAX_W-1:0] count;
      logic                 empty;
      logic                 full;
      logic                 overflow;
   } fifo_status_t;

endpackage

// File: rtl/fir_result_mem.sv
// Result storage: a DEPTH x DATA_W array with one synchronous write port and one registered read port.
module fir_result_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned PTR_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // The storage array is not reset; stale words are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // A read issued in the same cycle as a write to the same slot returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fir_result_fifo.sv
// FIR result FIFO: buffers accelerator results for the register interface, with overflow tracking and a fill-level IRQ.
module fir_result_fifo
   import fir_result_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned THRESH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic [DATA_W-1:0]        result_i,
   input  logic                     result_valid_i,
   input  logic                     rd_en_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     overflow_o,
   input  logic                     overflow_clr_i,
   output logic [DROP_W-1:0]        drop_cnt_o,
   output logic                     irq_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              rd_valid;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   fifo_status_t status_c;
   logic         pop_c;
   logic         wr_c;
   logic         drop_c;
   logic         mem_we_c;
   logic         mem_re_c;

   // Status and handshake decode from registered state only.
   always_comb begin
      status_c          = '0;
      status_c.count    = CNT_MAX_W'(count);
      status_c.empty    = (count == '0);
      status_c.full     = (count == CNT_W'(DEPTH));
      status_c.overflow = overflow;

      pop_c    = rd_en_i & ~status_c.empty;
      wr_c     = result_valid_i & (~status_c.full | pop_c);
      drop_c   = result_valid_i & status_c.full & ~pop_c;
      mem_we_c = wr_c & ~clr_i;
      mem_re_c = pop_c & ~clr_i;
   end

   fir_result_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .we    (mem_we_c),
      .waddr (wr_ptr),
      .wdata (result_i),
      .re    (mem_re_c),
      .raddr (rd_ptr),
      .rdata (rd_data_o)
   );

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else if (clr_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= mem_re_c;
         if (mem_we_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (mem_re_c) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({mem_we_c, mem_re_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Drop tracking; an explicit clear wins over a coincident drop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (clr_i || overflow_clr_i) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop_c) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

   assign rd_valid_o = rd_valid;
   assign count_o    = CNT_W'(status_c.count);
   assign empty_o    = status_c.empty;
   assign full_o     = status_c.full;
   assign overflow_o = status_c.overflow;
   assign drop_cnt_o = drop_cnt;
   assign irq_o      = (count >= CNT_W'(THRESH));

endmodule

// File: tb/tb_fir_result_fifo.sv
// Directed bench for fir_result_fifo: queue-based reference model checked every cycle, plus literal expectations.
module tb_fir_result_fifo;
   import fir_result_fifo_pkg::*;

   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned THRESH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic [DW-1:0] result;
   logic          rv;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [3:0]    count;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          oclr;
   logic [7:0]    drops;
   logic          irq;

   int n_checks = 0;
   int n_fail   = 0;

   fir_result_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clr_i          (clr),
      .result_i       (result),
      .result_valid_i (rv),
      .rd_en_i        (rd_en),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .count_o        (count),
      .empty_o        (empty),
      .full_o         (full),
      .overflow_o     (ovf),
      .overflow_clr_i (oclr),
      .drop_cnt_o     (drops),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored words plus the drop bookkeeping.
   logic [DW-1:0] mq[$];
   bit            m_ovf   = 1'b0;
   int            m_drops = 0;
   logic [DW-1:0] m_data  = '0;
   bit            m_valid = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
         m_data  = '0;
         m_valid = 1'b0;
      end else if (clr) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
         m_valid = 1'b0;
      end else begin
         bit was_full, do_pop, do_wr;
         was_full = (mq.size() == DEPTH);
         do_pop   = rd_en && (mq.size() > 0);
         do_wr    = rv && (!was_full || do_pop);
         m_valid  = do_pop;
         if (do_pop) m_data = mq.pop_front();
         if (do_wr) mq.push_back(result);
         if (rv && !do_wr) begin
            m_ovf   = 1'b1;
            m_drops = (m_drops < 255) ? m_drops + 1 : 255;
         end
         if (oclr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("m_count",    32'(count),    32'(mq.size()));
      check("m_empty",    32'(empty),    32'(mq.size() == 0));
      check("m_full",     32'(full),     32'(mq.size() == DEPTH));
      check("m_irq",      32'(irq),      32'(mq.size() >= THRESH));
      check("m_overflow", 32'(ovf),      32'(m_ovf));
      check("m_drop_cnt", 32'(drops),    32'(m_drops));
      check("m_rd_valid", 32'(rd_valid), 32'(m_valid));
      check("m_rd_data",  rd_data,       m_data);
   end

   task automatic write(input logic [DW-1:0] v);
      result = v;
      rv     = 1'b1;
      @(negedge clk);
      rv     = 1'b0;
   endtask

   task automatic pop_expect(input logic [DW-1:0] exp);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check("pop_valid", 32'(rd_valid), 32'd1);
      check("pop_data",  rd_data, exp);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; result = '0; rv = 1'b0; rd_en = 1'b0; oclr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_irq",   32'(irq),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three writes, three pops in order
      write(32'h11); write(32'h22); write(32'h33);
      check("w3_count", 32'(count), 32'd3);
      pop_expect(32'h11); pop_expect(32'h22); pop_expect(32'h33);
      check("p3_count", 32'(count), 32'd0);
      check("p3_empty", 32'(empty), 32'd1);
      @(negedge clk);
      check("p3_valid_low", 32'(rd_valid), 32'd0);

      // Fill to full, IRQ threshold, overflow on the ninth write
      for (int i = 1; i <= 8; i++) begin
         write(DW'(i));
         check("fill_irq", 32'(irq), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("fill_full", 32'(full), 32'd1);
      write(32'hAA);
      check("ovf_flag",  32'(ovf),   32'd1);
      check("ovf_drops", 32'(drops), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      for (int i = 1; i <= 8; i++) pop_expect(DW'(i));
      check("drain_empty", 32'(empty), 32'd1);
      oclr = 1'b1; @(negedge clk); oclr = 1'b0;
      check("oclr_flag", 32'(ovf), 32'd0);

      // Full FIFO with simultaneous write and pop
      for (int i = 0; i < 8; i++) write(DW'(32'h10 + i));
      result = 32'h99; rv = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      rv = 1'b0; rd_en = 1'b0;
      check("wp_data",  rd_data, 32'h10);
      check("wp_count", 32'(count), 32'd8);
      check("wp_ovf",   32'(ovf), 32'd0);
      for (int i = 1; i < 8; i++) pop_expect(DW'(32'h10 + i));
      pop_expect(32'h99);

      // Empty FIFO with simultaneous write and pop
      result = 32'h5; rv = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      rv = 1'b0; rd_en = 1'b0;
      check("ewp_valid", 32'(rd_valid), 32'd0);
      check("ewp_count", 32'(count), 32'd1);
      pop_expect(32'h5);

      // Drop counter saturation, then clear coincident with a drop
      for (int i = 0; i < 8; i++) write(DW'(32'h40 + i));
      result = 32'hEE; rv = 1'b1;
      repeat (300) @(negedge clk);
      check("sat_drops", 32'(drops), 32'd255);
      check("sat_ovf",   32'(ovf),   32'd1);
      oclr = 1'b1;
      @(negedge clk);
      oclr = 1'b0; rv = 1'b0;
      check("clr_drops", 32'(drops), 32'd0);
      check("clr_ovf",   32'(ovf),   32'd0);
      clr = 1'b1; @(negedge clk); clr = 1'b0;
      check("clr_empty", 32'(empty), 32'd1);

      // Synchronous clear beats a coincident write and pop
      for (int i = 0; i < 5; i++) write(DW'(32'h50 + i));
      check("f5_count", 32'(count), 32'd5);
      clr = 1'b1; result = 32'h77; rv = 1'b1; rd_en = 1'b1;
      @(negedge clk);
      clr = 1'b0; rv = 1'b0; rd_en = 1'b0;
      check("sclr_count", 32'(count), 32'd0);
      check("sclr_empty", 32'(empty), 32'd1);
      check("sclr_valid", 32'(rd_valid), 32'd0);
      check("sclr_data",  rd_data, 32'h5);

      // Asynchronous reset mid-fill, observed between clock edges
      write(32'h60); write(32'h61);
      pop_expect(32'h60);
      #2 rst_n = 1'b0;
      #1;
      check("arst_count", 32'(count),    32'd0);
      check("arst_empty", 32'(empty),    32'd1);
      check("arst_full",  32'(full),     32'd0);
      check("arst_data",  rd_data,       32'd0);
      check("arst_valid", 32'(rd_valid), 32'd0);
      check("arst_ovf",   32'(ovf),      32'd0);
      check("arst_drops", 32'(drops),    32'd0);
      check("arst_irq",   32'(irq),      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      write(32'h70);
      pop_expect(32'h70);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_result_fifo.md
FIR_RESULT_FIFO -- requirements
Module: fir_result_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of one FIR result word.
REQ-002 Parameter DEPTH, default 8, number of result entries; power of two, 2..64.
REQ-003 Parameter THRESH, default 4, fill level at which irq_o asserts; 1..DEPTH.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-006 clr_i  in  1  synchronous clear of FIFO contents and status, same-cycle pulse from the accelerator clear.
REQ-007 result_i  in  DATA_W  FIR MAC result from the accelerator core.
REQ-008 result_valid_i  in  1  one-cycle qualifier for result_i.
REQ-009 rd_en_i  in  1  pop request from the register-interface side.
REQ-010 rd_data_o  out  DATA_W  popped word; holds its value until the next accepted pop.
REQ-011 rd_valid_o  out  1  one-cycle pulse marking rd_data_o updated.
REQ-012 count_o  out  $clog2(DEPTH)+1  current number of stored entries.
REQ-013 empty_o / full_o  out  1 each  count_o==0 / count_o==DEPTH, combinational from count.
REQ-014 overflow_o  out  1  sticky flag: at least one result dropped.
REQ-015 overflow_clr_i  in  1  clears overflow_o and drop_cnt_o.
REQ-016 drop_cnt_o  out  8  saturating count of dropped results.
REQ-017 irq_o  out  1  level, high while count_o >= THRESH.

Function
REQ-018 Write accepted when result_valid_i=1 and (full_o=0 or pop accepted same cycle); word stored at write pointer; pointer increments and wraps modulo DEPTH.
REQ-019 Pop accepted when rd_en_i=1 and empty_o=0; next cycle rd_data_o = oldest entry, rd_valid_o=1 for exactly one cycle; read latency 1 cycle.
REQ-020 rd_en_i while empty: ignored, rd_valid_o stays 0, no state change, not an error.
REQ-021 Simultaneous accepted write and pop: count_o unchanged; when full, the popped entry is the oldest and the new word takes the freed slot.
REQ-022 Simultaneous write and pop while empty: write accepted, pop ignored; count_o becomes 1.
REQ-023 result_valid_i while full with no accepted pop: word dropped, contents unchanged, overflow_o set next cycle, drop_cnt_o increments, saturating at 255.
REQ-024 count_o arithmetic: +1 write only, -1 pop only, unchanged for both/neither; never exceeds DEPTH, never below 0.
REQ-025 overflow_clr_i coincident with a drop: clear wins; overflow_o=0, drop_cnt_o=0.
REQ-026 clr_i has priority over all other inputs: pointers and count to 0, overflow_o=0, drop_cnt_o=0, rd_valid_o=0 next cycle; coincident write and pop discarded; rd_data_o retains its value.
REQ-027 irq_o and flags registered-state derived; no combinational path from result_valid_i or rd_en_i to any output.

Reset
REQ-028 On rst_ni low, immediately: pointers=0, count_o=0, empty_o=1, full_o=0, rd_data_o=0, rd_valid_o=0, overflow_o=0, drop_cnt_o=0, irq_o=0.
REQ-029 Reset mid-operation discards all stored entries; storage array itself needs no reset.

Structure
REQ-030 DATA_W default, drop-counter width (8), and a fifo_status_t struct (count, empty, full, overflow) live in the shared accelerator package.
REQ-031 Storage is one sub-module, fir_result_mem: DEPTH x DATA_W array, one synchronous write port and one synchronous read port; pointer, count and flag logic stay in fir_result_fifo.

Verification
REQ-032 Reset, then write 3 results 0x11,0x22,0x33, pop 3 -> rd_data_o 0x11,0x22,0x33 each one cycle after pop, count_o 3->0, empty_o=1.
REQ-033 Write 8 results (DEPTH=8) -> full_o=1, irq_o=1 from count 4; 9th write 0xAA -> dropped, overflow_o=1, drop_cnt_o=1; pops return first 8 words only.
REQ-034 Full FIFO, simultaneous write 0x99 and pop -> count_o stays 8, no overflow; 8 further pops end with 0x99.
REQ-035 Empty FIFO, simultaneous write 0x5 and pop -> rd_valid_o=0, count_o=1; next pop returns 0x5.
REQ-036 Hold result_valid_i high 300 cycles while full -> drop_cnt_o saturates at 255; overflow_clr_i coincident with a drop -> both cleared.
REQ-037 Fill to 5 then clr_i with coincident write and pop -> count_o=0, empty_o=1, rd_valid_o=0; async rst_ni mid-fill -> all outputs at reset values without a clock edge.
